// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: bus width,
// general register count and the ALU opcode map.
// Imported by datapath and datapath_alu.
package datapath_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: operand A (from Y) and B (from bus) produce a 64-bit C.
// Ports: i_a, i_b operands; i_opcode operation; i_inc_pc forces C = B+1;
//        o_c result (single-word results in o_c[31:0], upper word zero).
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [4:0]         i_opcode,
  input  logic               i_inc_pc,
  output logic [2*WIDTH-1:0] o_c
);

  logic [4:0]                w_shamt;
  logic [5:0]                w_lshamt;
  logic [2*WIDTH-1:0]        w_rot;
  logic [WIDTH-1:0]          w_ror;
  logic [WIDTH-1:0]          w_rol;
  logic [WIDTH-1:0]          w_inc;
  logic signed [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]          w_quo;
  logic [WIDTH-1:0]          w_rem;

  assign w_shamt  = i_b[4:0];
  // Rotations are taken from the low word of {A,A} shifted right; a left
  // rotate by s equals a right rotate by 32-s (s=0 gives a 32-bit shift).
  assign w_lshamt = 6'd32 - {1'b0, w_shamt};
  assign w_rot    = {i_a, i_a};
  assign w_ror    = WIDTH'(w_rot >> w_shamt);
  assign w_rol    = WIDTH'(w_rot >> w_lshamt);
  assign w_inc    = i_b + WIDTH'(1);

  assign w_prod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) *
                  $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});

  // Divide-by-zero and the -1 divisor are handled explicitly so that the
  // most-negative / -1 overflow case wraps deterministically (quotient = -A).
  always_comb begin
    w_quo = '0;
    w_rem = '0;
    if (i_b == '0) begin
      w_quo = '0;
      w_rem = i_a;
    end else if (i_b == '1) begin
      w_quo = -i_a;
      w_rem = '0;
    end else begin
      w_quo = WIDTH'($signed(i_a) / $signed(i_b));
      w_rem = WIDTH'($signed(i_a) % $signed(i_b));
    end
  end

  always_comb begin
    o_c = '0;
    if (i_inc_pc) begin
      o_c = {{WIDTH{1'b0}}, w_inc};
    end else begin
      case (i_opcode)
        OP_ADD:  o_c = {{WIDTH{1'b0}}, i_a + i_b};
        OP_SUB:  o_c = {{WIDTH{1'b0}}, i_a - i_b};
        OP_AND:  o_c = {{WIDTH{1'b0}}, i_a & i_b};
        OP_OR:   o_c = {{WIDTH{1'b0}}, i_a | i_b};
        OP_SHR:  o_c = {{WIDTH{1'b0}}, i_a >> w_shamt};
        OP_SHRA: o_c = {{WIDTH{1'b0}}, WIDTH'($signed(i_a) >>> w_shamt)};
        OP_SHL:  o_c = {{WIDTH{1'b0}}, i_a << w_shamt};
        OP_ROR:  o_c = {{WIDTH{1'b0}}, w_ror};
        OP_ROL:  o_c = {{WIDTH{1'b0}}, w_rol};
        OP_MUL:  o_c = w_prod;
        OP_DIV:  o_c = {w_rem, w_quo};
        OP_NEG:  o_c = {{WIDTH{1'b0}}, -i_b};
        OP_NOT:  o_c = {{WIDTH{1'b0}}, ~i_b};
        default: o_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC, MAR, MDR, HI, LO, Y, Z and the
// shared bus mux feeding the ALU (A = Y, B = bus, result captured in Z).
// Ports: clock/clear (sync active-low), *in load strobes, *out bus selects,
//        Mdatain/Read for MDR, opcode/IncPC for the ALU, BusMuxOut/MARout observe.
module datapath
  import datapath_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [WIDTH-1:0]  Mdatain,
  input  logic              Read,
  input  logic              IncPC,
  input  logic [NREGS-1:0]  Rin,
  input  logic [NREGS-1:0]  Rout,
  input  logic              PCin,
  input  logic              Zin,
  input  logic              MDRin,
  input  logic              MARin,
  input  logic              Yin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              PCout,
  input  logic              Zhighout,
  input  logic              Zlowout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              MDRout,
  input  logic              Cout,
  input  logic [4:0]        opcode,
  output logic [WIDTH-1:0]  BusMuxOut,
  output logic [WIDTH-1:0]  MARout
);

  logic [WIDTH-1:0]   r_gpr [NREGS];
  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_mar;
  logic [WIDTH-1:0]   r_mdr;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_z;

  logic [WIDTH-1:0]   w_bus;
  logic [2*WIDTH-1:0] w_alu_c;

  // Bus mux: assignments run from lowest to highest priority, so the last
  // matching source wins. Rout[0] ends up highest, Cout (constant 0) lowest.
  always_comb begin
    w_bus = '0;
    if (Cout)     w_bus = '0;
    if (MDRout)   w_bus = r_mdr;
    if (LOout)    w_bus = r_lo;
    if (HIout)    w_bus = r_hi;
    if (Zlowout)  w_bus = r_z[WIDTH-1:0];
    if (Zhighout) w_bus = r_z[2*WIDTH-1:WIDTH];
    if (PCout)    w_bus = r_pc;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (Rout[i]) w_bus = r_gpr[i];
    end
  end

  datapath_alu u_alu (
    .i_a      (r_y),
    .i_b      (w_bus),
    .i_opcode (opcode),
    .i_inc_pc (IncPC),
    .o_c      (w_alu_c)
  );

  // All loads sample the current bus, so a register that both drives and
  // loads in one cycle reloads its old value; new values show next cycle.
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
      r_pc  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_y   <= '0;
      r_z   <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (Rin[i]) r_gpr[i] <= w_bus;
      end
      if (PCin)  r_pc  <= w_bus;
      if (MARin) r_mar <= w_bus;
      if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
      if (HIin)  r_hi  <= w_bus;
      if (LOin)  r_lo  <= w_bus;
      if (Yin)   r_y   <= w_bus;
      if (Zin)   r_z   <= w_alu_c;
    end
  end

  assign BusMuxOut = w_bus;
  assign MARout    = r_mar;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  import datapath_pkg::*;

  logic              clock;
  logic              clear;
  logic [WIDTH-1:0]  Mdatain;
  logic              Read, IncPC;
  logic [NREGS-1:0]  Rin, Rout;
  logic              PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
  logic              PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
  logic [4:0]        opcode;
  logic [WIDTH-1:0]  BusMuxOut, MARout;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
    .opcode(opcode), .BusMuxOut(BusMuxOut), .MARout(MARout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: expected values pushed by stimulus, popped by the monitor.
  logic [31:0] exp_val [$];
  bit          exp_mar [$];
  string       exp_nm  [$];
  bit          obs_vld;
  int          n_vec;
  int          n_bad;

  initial begin
    n_vec = 0;
    n_bad = 0;
    forever begin
      @(negedge clock);
      if (obs_vld) begin
        if (exp_val.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_underflow: observation with no expected value");
        end else begin
          logic [31:0] e, a;
          bit          m;
          string       nm;
          e  = exp_val.pop_front();
          m  = exp_mar.pop_front();
          nm = exp_nm.pop_front();
          a  = m ? MARout : BusMuxOut;
          n_vec++;
          if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, a, e);
          end
        end
      end
    end
  end

  task automatic clr_ctl();
    Mdatain = '0; Read = 0; IncPC = 0; Rin = '0; Rout = '0;
    PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
    PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
    opcode = '0;
  endtask

  // Apply current controls for one edge, then return to idle.
  task automatic tick();
    @(posedge clock);
    #1;
    obs_vld = 0;
    clr_ctl();
  endtask

  // Controls already set up; the monitor compares during this cycle.
  task automatic chk(input string nm, input logic [31:0] v, input bit mar);
    exp_val.push_back(v);
    exp_mar.push_back(mar);
    exp_nm.push_back(nm);
    obs_vld = 1;
    tick();
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic reg_from_mdr(input int r, input logic [31:0] v);
    mdr_load(v);
    MDRout = 1; Rin[r] = 1;
    tick();
  endtask

  task automatic rd_reg(input string nm, input int r, input logic [31:0] v);
    Rout[r] = 1;
    chk(nm, v, 0);
  endtask

  initial begin
    obs_vld = 0;
    clr_ctl();
    clear = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1;

    // Reset state
    rd_reg("rst_R1", 1, 32'h0);
    PCout = 1;    chk("rst_PC", 32'h0, 0);
    Zlowout = 1;  chk("rst_Zlow", 32'h0, 0);
    Zhighout = 1; chk("rst_Zhigh", 32'h0, 0);
    MDRout = 1;   chk("rst_MDR", 32'h0, 0);
    chk("rst_MAR", 32'h0, 1);

    // Test 1: dirty state, then synchronous clear with load enables active
    reg_from_mdr(1, 32'h5);
    rd_reg("t1_R1", 1, 32'h5);
    Rout[1] = 1; Yin = 1; PCin = 1; tick();
    Rout[1] = 1; opcode = OP_ADD; Zin = 1; tick();      // Z = 5+5
    Zlowout = 1;  chk("t1_Zlow_add", 32'hA, 0);
    clear = 0; Rout[1] = 1; Rin[1] = 1; PCin = 1; Yin = 1; Zin = 1; opcode = OP_ADD;
    tick();
    clear = 1;
    rd_reg("clr_R1", 1, 32'h0);
    PCout = 1;   chk("clr_PC", 32'h0, 0);
    Zlowout = 1; chk("clr_Zlow", 32'h0, 0);
    Cout = 1; opcode = OP_ADD; Zin = 1; tick();         // Z = Y + 0
    Zlowout = 1; chk("clr_Y", 32'h0, 0);
    mdr_load(32'h9);
    MDRout = 1;  chk("resume_MDR", 32'h9, 0);

    // Test 2: register loads via MDR
    reg_from_mdr(3, 32'h12);
    reg_from_mdr(5, 32'h14);
    reg_from_mdr(1, 32'h18);
    rd_reg("t2_R3", 3, 32'h12);
    rd_reg("t2_R5", 5, 32'h14);
    rd_reg("t2_R1", 1, 32'h18);

    // Test 3: shr, only B[4:0] used
    Rout[3] = 1; Yin = 1; tick();
    Rout[5] = 1; opcode = OP_SHR; Zin = 1; tick();
    Zlowout = 1; Rin[1] = 1; chk("t3_Zlow_shr20", 32'h0, 0);
    rd_reg("t3_R1_shr20", 1, 32'h0);
    reg_from_mdr(5, 32'h2);
    Rout[5] = 1; opcode = OP_SHR; Zin = 1; tick();
    Zlowout = 1; Rin[1] = 1; tick();
    rd_reg("t3_R1_shr2", 1, 32'h4);

    // Test 4: fetch increment (IncPC overrides opcode)
    mdr_load(32'h7);
    MDRout = 1; PCin = 1; tick();
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; opcode = OP_MUL; tick();
    chk("t4_MAR", 32'h7, 1);
    Zlowout = 1;  chk("t4_Zlow_inc", 32'h8, 0);
    Zhighout = 1; chk("t4_Zhigh_inc", 32'h0, 0);
    Zlowout = 1; PCin = 1; tick();
    PCout = 1;   chk("t4_PC", 32'h8, 0);

    // Test 5: signed mul / div
    mdr_load(32'hFFFF_FFFE);
    MDRout = 1; Yin = 1; tick();
    mdr_load(32'h3);
    MDRout = 1; opcode = OP_MUL; Zin = 1; tick();
    Zhighout = 1; chk("t5_mul_hi", 32'hFFFF_FFFF, 0);
    Zlowout = 1;  chk("t5_mul_lo", 32'hFFFF_FFFA, 0);
    mdr_load(32'd17);
    MDRout = 1; Yin = 1; tick();
    mdr_load(32'd5);
    MDRout = 1; opcode = OP_DIV; Zin = 1; tick();
    Zlowout = 1; LOin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    LOout = 1; chk("t5_LO_quo", 32'd3, 0);
    HIout = 1; chk("t5_HI_rem", 32'd2, 0);
    // Y=17, MDR=5: sub, ror, divide by zero
    MDRout = 1; opcode = OP_SUB; Zin = 1; tick();
    Zlowout = 1; chk("sub_lo", 32'd12, 0);
    MDRout = 1; opcode = OP_ROR; Zin = 1; tick();
    Zlowout = 1; chk("ror_lo", 32'h8800_0000, 0);
    Cout = 1; opcode = OP_DIV; Zin = 1; tick();
    Zhighout = 1; chk("div0_hi", 32'd17, 0);
    Zlowout = 1;  chk("div0_lo", 32'h0, 0);

    // Test 6: bus priority and idle bus
    reg_from_mdr(2, 32'hAB);
    Rout[2] = 1; PCout = 1; chk("t6_prio_R2_PC", 32'hAB, 0);
    Rout[2] = 1; Rout[9] = 1; chk("t6_prio_R2_R9", 32'hAB, 0);
    MDRout = 1; Cout = 1; chk("t6_prio_MDR_C", 32'hAB, 0);
    chk("t6_idle", 32'h0, 0);
    // Same-register read and write: bus shows old value this cycle
    Rout[2] = 1; LOout = 1; Rin[2] = 1; chk("rw_old_R2", 32'hAB, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_val.size() != 0; i++) @(posedge clock);
    if (exp_val.size() != 0) begin
      n_bad += exp_val.size();
      $display("FAIL drain: %0d expected values never observed, required 0", exp_val.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
